priority_encoder_rr: RTL and testbench

Parametrised, registered priority encoder with valid/ready handshake and selectable fixed or round-robin priority. Reduces a WIDTH-bit request vector to the index of the winning bit plus a "no request" flag, one result per accepted input. It succeeds the 8-to-3 combinational encoder in the A1 datapath, where it arbitrates between request sources and must tolerate downstream backpressure.

---
 rtl/prio_enc_pkg.sv | 19 +
 rtl/priority_encoder_rr_scan.sv | 33 +++
 rtl/priority_encoder_rr.sv | 89 ++++++++
 tb/tb_priority_encoder_rr.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// Shared types and constants for the registered priority encoder.
package prio_enc_pkg;

  typedef enum logic {
    PRIO_FIXED = 1'b0,
    PRIO_RR    = 1'b1
  } prio_mode_e;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } out_state_e;

  // Pointer value after reset: the top index has highest priority.
  function automatic int reset_ptr(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/priority_encoder_rr_scan.sv
// priority_scan: combinational search for the first set request bit,
// walking downward from a start index and wrapping past bit 0.
module priority_scan #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             none
);

  int               p;
  logic [IDX_W-1:0] pos;

  // Iterate from the farthest distance to the nearest so the closest hit wins.
  always_comb begin
    idx  = '0;
    none = 1'b1;
    p    = 0;
    pos  = '0;
    for (int d = WIDTH - 1; d >= 0; d--) begin
      p = int'(start) - d;
      if (p < 0) p = p + WIDTH;
      pos = IDX_W'(p);
      if (req[pos]) begin
        idx  = pos;
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/priority_encoder_rr.sv
// Registered priority encoder, fixed or round-robin, with a one-entry
// valid/ready output stage. Define PRIO_ENC_ONEHOT_EN to add grant_onehot.
module priority_encoder_rr
  import prio_enc_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_req,
  input  logic             mode,
  output logic             in_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_none,
  input  logic             out_ready
`ifdef PRIO_ENC_ONEHOT_EN
  ,
  output logic [WIDTH-1:0] grant_onehot
`endif
);

  // Handshake: a beat moves when valid && ready on the same rising edge;
  // in_ready depends only on the registered out_valid and on out_ready.
  out_state_e       state, state_next;
  logic             accept;
  logic [IDX_W-1:0] ptr, scan_start, scan_idx;
  logic             scan_none;
  prio_mode_e       mode_e;

  assign mode_e     = prio_mode_e'(mode);
  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign scan_start = (mode_e == PRIO_RR) ? ptr : IDX_W'(reset_ptr(WIDTH));

  priority_scan #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_scan (
    .req   (in_req),
    .start (scan_start),
    .idx   (scan_idx),
    .none  (scan_none)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_EMPTY: if (accept) state_next = S_FULL;
      S_FULL:  if (out_ready && !accept) state_next = S_EMPTY;
      default: state_next = S_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state == S_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_idx  <= '0;
      out_none <= 1'b0;
    end else if (accept) begin
      out_idx  <= scan_none ? '0 : scan_idx;
      out_none <= scan_none;
    end
  end

  // The winner drops to lowest priority for the next round-robin search.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= IDX_W'(reset_ptr(WIDTH));
    end else if (accept && mode_e == PRIO_RR && !scan_none) begin
      ptr <= (scan_idx == '0) ? IDX_W'(reset_ptr(WIDTH)) : scan_idx - 1'b1;
    end
  end

`ifdef PRIO_ENC_ONEHOT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         grant_onehot <= '0;
    else if (accept) grant_onehot <= scan_none ? '0 : (WIDTH'(1) << scan_idx);
  end
`endif

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Directed and randomized bench for priority_encoder_rr (WIDTH=8 and WIDTH=16).
module tb_priority_encoder_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, mode, out_ready;
  logic [7:0] in_req;
  logic       in_ready, out_valid, out_none;
  logic [2:0] out_idx;
  logic        in_valid16, mode16, out_ready16;
  logic [15:0] in_req16;
  logic        in_ready16, out_valid16, out_none16;
  logic [3:0]  out_idx16;
`ifdef PRIO_ENC_ONEHOT_EN
  logic [7:0]  grant_onehot;
  logic [15:0] grant_onehot16;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state: result register contents and round-robin pointer.
  logic       m_valid, m_none;
  int         m_idx, m_ptr;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  priority_encoder_rr #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_req(in_req), .mode(mode),
    .in_ready(in_ready), .out_valid(out_valid), .out_idx(out_idx),
    .out_none(out_none), .out_ready(out_ready)
`ifdef PRIO_ENC_ONEHOT_EN
    , .grant_onehot(grant_onehot)
`endif
  );

  priority_encoder_rr #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_req(in_req16), .mode(mode16),
    .in_ready(in_ready16), .out_valid(out_valid16), .out_idx(out_idx16),
    .out_none(out_none16), .out_ready(out_ready16)
`ifdef PRIO_ENC_ONEHOT_EN
    , .grant_onehot(grant_onehot16)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First set bit in the order start, start-1, ..., wrapping modulo w; -1 if none.
  function automatic int win(input logic [15:0] req, input int start, input int w);
    for (int k = 0; k < w; k++) begin
      int pos;
      pos = (start - k + w) % w;
      if (req[pos]) return pos;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_none = 1'b0; m_idx = 0; m_ptr = 7;
    exp_q.delete();
  endtask

  // Drive one cycle on the 8-bit DUT; called at posedge+1, returns at posedge+1.
  task automatic step(input logic v, input logic [7:0] r, input logic md, input logic rdy);
    logic acc;
    int   w;
    logic [3:0] e;
    in_valid = v; in_req = r; mode = md; out_ready = rdy;
    #1;
    chk("in_ready", in_ready, (!m_valid) || rdy);
    if (m_valid && rdy && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("beat", {out_none, out_idx}, e);
    end
    acc = v && ((!m_valid) || rdy);
    w = acc ? win({8'h00, r}, md ? m_ptr : 7, 8) : 0;
    @(posedge clk); #1;
    if (acc) begin
      m_valid = 1'b1;
      m_none  = (w < 0);
      m_idx   = (w < 0) ? 0 : w;
      if (md && w >= 0) m_ptr = (w + 7) % 8;
      exp_q.push_back({m_none, 3'(m_idx)});
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    chk("out_valid", out_valid, m_valid);
    chk("out_idx", out_idx, m_idx);
    chk("out_none", out_none, m_none);
`ifdef PRIO_ENC_ONEHOT_EN
    chk("grant_onehot", grant_onehot, m_none ? 0 : (1 << m_idx));
`endif
  endtask

  task automatic step16(input logic [15:0] r, input logic md, input int exp_idx);
    in_valid16 = 1'b1; in_req16 = r; mode16 = md; out_ready16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    chk("out_valid16", out_valid16, 1'b1);
    chk("out_idx16", out_idx16, exp_idx);
    chk("out_none16", out_none16, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_req = '0; mode = 1'b0; out_ready = 1'b0;
    in_valid16 = 1'b0; in_req16 = '0; mode16 = 1'b0; out_ready16 = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_none", out_none, 1'b0);
`ifdef PRIO_ENC_ONEHOT_EN
    chk("rst_onehot", grant_onehot, 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Fixed priority, back-to-back: expect 4, 6, 7, 2.
    step(1, 8'b00010000, 0, 1); chk("fixed_a", out_idx, 4);
    step(1, 8'b01000100, 0, 1); chk("fixed_b", out_idx, 6);
    step(1, 8'b11110000, 0, 1); chk("fixed_c", out_idx, 7);
    step(1, 8'b00000110, 0, 1); chk("fixed_d", out_idx, 2);
    step(0, 8'h00, 0, 1);

    // Round-robin rotation and wrap: 7, 6, 5, 4, then 0, then 7.
    step(1, 8'hFF, 1, 1); chk("rr_a", out_idx, 7);
    step(1, 8'hFF, 1, 1); chk("rr_b", out_idx, 6);
    step(1, 8'hFF, 1, 1); chk("rr_c", out_idx, 5);
    step(1, 8'hFF, 1, 1); chk("rr_d", out_idx, 4);
    step(1, 8'h81, 1, 1); chk("rr_wrap", out_idx, 0);
    step(1, 8'h81, 1, 1); chk("rr_again", out_idx, 7);

    // Zero vector is a valid beat and leaves the pointer at 6.
    step(1, 8'h00, 1, 1); chk("zero_none", out_none, 1'b1); chk("zero_idx", out_idx, 0);
    step(1, 8'hFF, 1, 1); chk("zero_ptr_kept", out_idx, 6);
    step(0, 8'h00, 0, 1);

    // Backpressure: hold for 5 cycles, then pop and replace on the same edge.
    step(1, 8'b00100000, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 8'($urandom), 0, 0);
      chk("bp_hold_idx", out_idx, 5);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    step(1, 8'b01000100, 0, 1); chk("bp_replace", out_idx, 6);
    step(0, 8'h00, 0, 1);

    // Asynchronous reset between edges while FULL in RR mode.
    step(1, 8'h0F, 1, 0);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_out_idx", out_idx, 0);
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("post_rst_valid", out_valid, 1'b0);
    step(1, 8'hFF, 1, 1); chk("post_rst_rr", out_idx, 7);
    step(0, 8'h00, 0, 1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      if ($urandom_range(0, 7) == 0) r = '0;
      step($urandom_range(0, 3) != 0, r, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end
    step(0, 8'h00, 0, 1);

    // WIDTH=16: RR wrap then fixed priority.
    step16(16'h8001, 1, 15);
    step16(16'h8001, 1, 0);
    step16(16'h0300, 0, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
